// File: rtl/tdm_demux16.sv
// Receive end of a 16-channel TDM link: aligns to frame_sync, assembles 16 slots
// into a shadow register, presents complete frames on ch_out and tracks frame lock.
module tdm_demux16 #(
    parameter int DATA_W     = 1,
    parameter int MISS_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [16*DATA_W-1:0] ch_out,
    output logic                 frame_valid,
    output logic [3:0]           slot,
    output logic                 locked,
    output logic                 sync_err
);

    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            slot_q, slot_d;
    logic [MISS_W-1:0]     miss_cnt_q, miss_cnt_d;
    logic [MISS_W-1:0]     miss_inc;
    logic [16*DATA_W-1:0]  shadow_q, shadow_d;
    logic [16*DATA_W-1:0]  ch_out_q, ch_out_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  sync_err_q, sync_err_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        slot_d        = slot_q;
        miss_cnt_d    = miss_cnt_q;
        miss_inc      = miss_cnt_q + MISS_W'(1);
        shadow_d      = shadow_q;
        ch_out_d      = ch_out_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0 +: DATA_W] = din;
                        slot_d                = 4'd1;
                        miss_cnt_d            = '0;
                        state_d               = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && slot_q != 4'd0) begin
                        // Early sync: abandon the partial frame and restart at slot 0.
                        sync_err_d            = 1'b1;
                        shadow_d[0 +: DATA_W] = din;
                        slot_d                = 4'd1;
                        miss_cnt_d            = '0;
                    end else if (slot_q == 4'd0 && !frame_sync) begin
                        if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                            state_d    = HUNT;
                            slot_d     = 4'd0;
                            miss_cnt_d = '0;
                        end else begin
                            // Flywheel: trust the slot counter for this frame.
                            miss_cnt_d            = miss_inc;
                            shadow_d[0 +: DATA_W] = din;
                            slot_d                = 4'd1;
                        end
                    end else if (slot_q == 4'd0) begin
                        miss_cnt_d            = '0;
                        shadow_d[0 +: DATA_W] = din;
                        slot_d                = 4'd1;
                    end else begin
                        shadow_d[int'(slot_q)*DATA_W +: DATA_W] = din;
                        slot_d                                  = slot_q + 4'd1;
                        if (slot_q == 4'd15) begin
                            ch_out_d      = {din, shadow_q[15*DATA_W-1:0]};
                            frame_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 4'd0;
            miss_cnt_q    <= '0;
            shadow_q      <= '0;
            ch_out_q      <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q       <= state_d;
            slot_q        <= slot_d;
            miss_cnt_q    <= miss_cnt_d;
            shadow_q      <= shadow_d;
            ch_out_q      <= ch_out_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign ch_out      = ch_out_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16: stimulus pushes expected frame / sync_err events
// into a queue; a monitor pops and compares whenever the DUT pulses an output.
module tb_tdm_demux16;

    localparam int DATA_W = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DATA_W-1:0]    din;
    logic                 din_valid;
    logic                 frame_sync;
    logic [16*DATA_W-1:0] ch_out;
    logic                 frame_valid;
    logic [3:0]           slot;
    logic                 locked;
    logic                 sync_err;

    typedef struct packed {
        logic        is_err;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    tdm_demux16 #(.DATA_W(DATA_W), .MISS_LIMIT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch_out     (ch_out),
        .frame_valid(frame_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (frame_valid || sync_err)) begin
            ev_t e;
            check("pulses_exclusive", {31'd0, frame_valid & sync_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, frame_valid, sync_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {31'd0, sync_err}, {31'd0, e.is_err});
                if (!e.is_err) check("frame_data", {16'd0, ch_out}, {16'd0, e.data});
            end
        end
    end

    // Drive one cycle of inputs; outputs reflect this beat on return.
    task automatic beat(input logic v, input logic s, input logic d);
        din        = d;
        din_valid  = v;
        frame_sync = s;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] data, input logic with_sync, input logic gaps);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) exp_q.push_back('{is_err: 1'b0, data: data});
            beat(1'b1, with_sync && i == 0, data[i]);
            if (i == 0) begin
                check("locked_after_slot0", {31'd0, locked}, 32'd1);
                check("slot_after_slot0", {28'd0, slot}, 32'd1);
            end
            if (gaps && i != 15) beat(1'b0, 1'b1, 1'b1);
        end
        check("frame_valid_latency", {31'd0, frame_valid}, 32'd1);
        check("slot_wrapped", {28'd0, slot}, 32'd0);
        beat(1'b0, 1'b0, 1'b0);
        check("frame_valid_one_cycle", {31'd0, frame_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
        @(negedge clk); @(negedge clk);
        check("reset_ch_out", {16'd0, ch_out}, 32'd0);
        check("reset_locked", {31'd0, locked}, 32'd0);
        check("reset_slot", {28'd0, slot}, 32'd0);
        check("reset_pulses", {30'd0, frame_valid, sync_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, LSB first
        send_frame(16'hA5C3, 1'b1, 1'b0);
        check("t2_locked", {31'd0, locked}, 32'd1);

        // Same frame with gaps; gap beats carry sync/data that must be ignored
        send_frame(16'hA5C3, 1'b1, 1'b1);

        // Early sync at slot 5
        pat = 16'hFFFF;
        for (int i = 0; i < 5; i++) beat(1'b1, i == 0, pat[i]);
        check("t4_slot5", {28'd0, slot}, 32'd5);
        exp_q.push_back('{is_err: 1'b1, data: 16'h0});
        send_frame(16'h1234, 1'b1, 1'b0);

        // Flywheel over two missed syncs, drop lock on the third
        send_frame(16'h0F0F, 1'b0, 1'b0);
        send_frame(16'hF00F, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
        check("t5_lock_dropped", {31'd0, locked}, 32'd0);
        check("t5_slot_hunt", {28'd0, slot}, 32'd0);
        check("t5_ch_out_hold", {16'd0, ch_out}, 32'h0000F00F);

        // Hunt: no sync for 20 beats
        for (int i = 0; i < 20; i++) beat(1'b1, 1'b0, 1'(i));
        check("t6_slot_stays0", {28'd0, slot}, 32'd0);
        check("t6_still_hunt", {31'd0, locked}, 32'd0);
        send_frame(16'h5AA5, 1'b1, 1'b0);

        // Asynchronous reset mid-frame, away from any clock edge
        for (int i = 0; i < 7; i++) beat(1'b1, i == 0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t1_async_ch_out", {16'd0, ch_out}, 32'd0);
        check("t1_async_locked", {31'd0, locked}, 32'd0);
        check("t1_async_slot", {28'd0, slot}, 32'd0);
        check("t1_async_pulses", {30'd0, frame_valid, sync_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        beat(1'b0, 1'b0, 1'b0);

        check("expected_events_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
